// File: rtl/e203_exu_oitf_ooo.sv
`default_nettype none
// ============================================================================
// Module   : e203_exu_oitf_ooo
// Brief    : Outstanding instruction track FIFO with out-of-order completion
//            marking by ITAG and an in-order valid/ready retire handshake.
//            Optional flush port enabled by macro E203_OITF_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module e203_exu_oitf_ooo #(
   parameter int DEPTH   = 4,
   parameter int ITAG_W  = 2,
   parameter int RFIDX_W = 5,
   parameter int PC_W    = 32,
   parameter int CNT_W   = 3
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef E203_OITF_FLUSH_EN
   input  logic               flush_req,
`endif
   input  logic               dis_ena,
   output logic               dis_ready,
   output logic [ITAG_W-1:0]  dis_ptr,
   input  logic               disp_i_rs1en,
   input  logic               disp_i_rs2en,
   input  logic               disp_i_rs3en,
   input  logic               disp_i_rdwen,
   input  logic               disp_i_rs1fpu,
   input  logic               disp_i_rs2fpu,
   input  logic               disp_i_rs3fpu,
   input  logic               disp_i_rdfpu,
   input  logic [RFIDX_W-1:0] disp_i_rs1idx,
   input  logic [RFIDX_W-1:0] disp_i_rs2idx,
   input  logic [RFIDX_W-1:0] disp_i_rs3idx,
   input  logic [RFIDX_W-1:0] disp_i_rdidx,
   input  logic [PC_W-1:0]    disp_i_pc,
   input  logic               cmt_ena,
   input  logic [ITAG_W-1:0]  cmt_itag,
   output logic               ret_valid,
   input  logic               ret_ready,
   output logic [ITAG_W-1:0]  ret_ptr,
   output logic [RFIDX_W-1:0] ret_rdidx,
   output logic               ret_rdwen,
   output logic               ret_rdfpu,
   output logic [PC_W-1:0]    ret_pc,
   output logic               oitfrd_match_disprs1,
   output logic               oitfrd_match_disprs2,
   output logic               oitfrd_match_disprs3,
   output logic               oitfrd_match_disprd,
   output logic               oitf_empty,
   output logic               oitf_full,
   output logic [CNT_W-1:0]   oitf_cnt
);

   localparam logic [ITAG_W-1:0] c_LAST = ITAG_W'(DEPTH - 1);

   logic [ITAG_W-1:0]  alc_ptr_q, alc_ptr_d, ret_ptr_q, ret_ptr_d;
   logic               alc_flg_q, alc_flg_d, ret_flg_q, ret_flg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DEPTH-1:0]   vld_q, vld_d, done_q, done_d;
   logic [RFIDX_W-1:0] rdidx_q [DEPTH];
   logic               rdwen_q [DEPTH];
   logic               rdfpu_q [DEPTH];
   logic [PC_W-1:0]    pc_q    [DEPTH];
   logic               w_alc, w_fire, w_head_vld, w_head_done;

   assign oitf_full  = (alc_ptr_q == ret_ptr_q) & (alc_flg_q != ret_flg_q);
   assign oitf_empty = (alc_ptr_q == ret_ptr_q) & (alc_flg_q == ret_flg_q);
   assign dis_ready  = ~oitf_full;
   assign dis_ptr    = alc_ptr_q;
   assign ret_ptr    = ret_ptr_q;
   assign oitf_cnt   = cnt_q;
   // Allocation depends only on registered fullness, never on same-cycle retire
   assign w_alc      = dis_ena & ~oitf_full;
   assign ret_valid  = w_head_vld & w_head_done;
   assign w_fire     = ret_valid & ret_ready;

   // Head-entry read mux driven by the retire pointer
   always_comb begin
      w_head_vld  = 1'b0;
      w_head_done = 1'b0;
      ret_rdidx   = '0;
      ret_rdwen   = 1'b0;
      ret_rdfpu   = 1'b0;
      ret_pc      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ret_ptr_q == ITAG_W'(i)) begin
            w_head_vld  = vld_q[i];
            w_head_done = done_q[i];
            ret_rdidx   = rdidx_q[i];
            ret_rdwen   = rdwen_q[i];
            ret_rdfpu   = rdfpu_q[i];
            ret_pc      = pc_q[i];
         end
      end
   end

   // Hazard match: any valid entry writing the same register in the same file
   always_comb begin
      oitfrd_match_disprs1 = 1'b0;
      oitfrd_match_disprs2 = 1'b0;
      oitfrd_match_disprs3 = 1'b0;
      oitfrd_match_disprd  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] & rdwen_q[i]) begin
            oitfrd_match_disprs1 |= disp_i_rs1en & (rdfpu_q[i] == disp_i_rs1fpu) & (rdidx_q[i] == disp_i_rs1idx);
            oitfrd_match_disprs2 |= disp_i_rs2en & (rdfpu_q[i] == disp_i_rs2fpu) & (rdidx_q[i] == disp_i_rs2idx);
            oitfrd_match_disprs3 |= disp_i_rs3en & (rdfpu_q[i] == disp_i_rs3fpu) & (rdidx_q[i] == disp_i_rs3idx);
            oitfrd_match_disprd  |= disp_i_rdwen & (rdfpu_q[i] == disp_i_rdfpu)  & (rdidx_q[i] == disp_i_rdidx);
         end
      end
   end

   // Next-state for entry flags, pointers and occupancy counter
   always_comb begin
      vld_d     = vld_q;
      done_d    = done_q;
      alc_ptr_d = alc_ptr_q;
      alc_flg_d = alc_flg_q;
      ret_ptr_d = ret_ptr_q;
      ret_flg_d = ret_flg_q;
      cnt_d     = cnt_q;
      for (int i = 0; i < DEPTH; i++) begin
         // Out-of-range tags never equal any entry index, so they fall out here
         if (cmt_ena && (cmt_itag == ITAG_W'(i)) && vld_q[i] && !done_q[i]) begin
            done_d[i] = 1'b1;
         end
         if (w_fire && (ret_ptr_q == ITAG_W'(i))) begin
            vld_d[i]  = 1'b0;
            done_d[i] = 1'b0;
         end
         if (w_alc && (alc_ptr_q == ITAG_W'(i))) begin
            vld_d[i]  = 1'b1;
            done_d[i] = 1'b0;
         end
      end
      if (w_alc) begin
         if (alc_ptr_q == c_LAST) begin
            alc_ptr_d = '0;
            alc_flg_d = ~alc_flg_q;
         end else begin
            alc_ptr_d = alc_ptr_q + ITAG_W'(1);
         end
      end
      if (w_fire) begin
         if (ret_ptr_q == c_LAST) begin
            ret_ptr_d = '0;
            ret_flg_d = ~ret_flg_q;
         end else begin
            ret_ptr_d = ret_ptr_q + ITAG_W'(1);
         end
      end
      if (w_alc && !w_fire) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!w_alc && w_fire) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
`ifdef E203_OITF_FLUSH_EN
      // Flush overrides every other event in the same cycle
      if (flush_req) begin
         vld_d     = '0;
         done_d    = '0;
         alc_ptr_d = '0;
         alc_flg_d = 1'b0;
         ret_ptr_d = '0;
         ret_flg_d = 1'b0;
         cnt_d     = '0;
      end
`endif
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q     <= '0;
         done_q    <= '0;
         alc_ptr_q <= '0;
         alc_flg_q <= 1'b0;
         ret_ptr_q <= '0;
         ret_flg_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         vld_q     <= vld_d;
         done_q    <= done_d;
         alc_ptr_q <= alc_ptr_d;
         alc_flg_q <= alc_flg_d;
         ret_ptr_q <= ret_ptr_d;
         ret_flg_q <= ret_flg_d;
         cnt_q     <= cnt_d;
      end
   end

   // Payload capture on allocation; no reset since it is qualified by vld
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (w_alc && (alc_ptr_q == ITAG_W'(i))) begin
            rdidx_q[i] <= disp_i_rdidx;
            rdwen_q[i] <= disp_i_rdwen;
            rdfpu_q[i] <= disp_i_rdfpu;
            pc_q[i]    <= disp_i_pc;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_e203_exu_oitf_ooo.sv
`default_nettype none
// ============================================================================
// Module   : tb_e203_exu_oitf_ooo
// Brief    : Directed self-checking bench; DEPTH=4 and DEPTH=3 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e203_exu_oitf_ooo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rs1en, rs2en, rs3en, rdwen, rs1fpu, rs2fpu, rs3fpu, rdfpu;
   logic [4:0]  rs1idx, rs2idx, rs3idx, rdidx;
   logic [31:0] pc;
   int          n_vec = 0;
   int          n_err = 0;
   int          ea, er;

   // DEPTH=4 instance signals
   logic        dis_ena, cmt_ena, ret_ready;
   logic [1:0]  cmt_itag;
   logic        dis_ready, ret_valid, ret_rdwen, ret_rdfpu, m1, m2, m3, md, empty, full;
   logic [1:0]  dis_ptr, ret_ptr;
   logic [4:0]  ret_rdidx;
   logic [31:0] ret_pc;
   logic [2:0]  cnt;
`ifdef E203_OITF_FLUSH_EN
   logic        flush_req, flush3;
`endif

   // DEPTH=3 instance signals
   logic        dis_ena3, cmt_ena3, ret_ready3;
   logic [1:0]  cmt_itag3;
   logic        dis_ready3, ret_valid3, ret_rdwen3, ret_rdfpu3, m13, m23, m33, md3, empty3, full3;
   logic [1:0]  dis_ptr3, ret_ptr3;
   logic [4:0]  ret_rdidx3;
   logic [31:0] ret_pc3;
   logic [2:0]  cnt3;

   always #5 clk = ~clk;

   e203_exu_oitf_ooo #(.DEPTH(4), .ITAG_W(2), .RFIDX_W(5), .PC_W(32), .CNT_W(3)) u_dut (
      .clk(clk), .rst_n(rst_n),
`ifdef E203_OITF_FLUSH_EN
      .flush_req(flush_req),
`endif
      .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_ptr(dis_ptr),
      .disp_i_rs1en(rs1en), .disp_i_rs2en(rs2en), .disp_i_rs3en(rs3en), .disp_i_rdwen(rdwen),
      .disp_i_rs1fpu(rs1fpu), .disp_i_rs2fpu(rs2fpu), .disp_i_rs3fpu(rs3fpu), .disp_i_rdfpu(rdfpu),
      .disp_i_rs1idx(rs1idx), .disp_i_rs2idx(rs2idx), .disp_i_rs3idx(rs3idx), .disp_i_rdidx(rdidx),
      .disp_i_pc(pc), .cmt_ena(cmt_ena), .cmt_itag(cmt_itag),
      .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_ptr(ret_ptr), .ret_rdidx(ret_rdidx),
      .ret_rdwen(ret_rdwen), .ret_rdfpu(ret_rdfpu), .ret_pc(ret_pc),
      .oitfrd_match_disprs1(m1), .oitfrd_match_disprs2(m2), .oitfrd_match_disprs3(m3),
      .oitfrd_match_disprd(md), .oitf_empty(empty), .oitf_full(full), .oitf_cnt(cnt)
   );

   e203_exu_oitf_ooo #(.DEPTH(3), .ITAG_W(2), .RFIDX_W(5), .PC_W(32), .CNT_W(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
`ifdef E203_OITF_FLUSH_EN
      .flush_req(flush3),
`endif
      .dis_ena(dis_ena3), .dis_ready(dis_ready3), .dis_ptr(dis_ptr3),
      .disp_i_rs1en(rs1en), .disp_i_rs2en(rs2en), .disp_i_rs3en(rs3en), .disp_i_rdwen(rdwen),
      .disp_i_rs1fpu(rs1fpu), .disp_i_rs2fpu(rs2fpu), .disp_i_rs3fpu(rs3fpu), .disp_i_rdfpu(rdfpu),
      .disp_i_rs1idx(rs1idx), .disp_i_rs2idx(rs2idx), .disp_i_rs3idx(rs3idx), .disp_i_rdidx(rdidx),
      .disp_i_pc(pc), .cmt_ena(cmt_ena3), .cmt_itag(cmt_itag3),
      .ret_valid(ret_valid3), .ret_ready(ret_ready3), .ret_ptr(ret_ptr3), .ret_rdidx(ret_rdidx3),
      .ret_rdwen(ret_rdwen3), .ret_rdfpu(ret_rdfpu3), .ret_pc(ret_pc3),
      .oitfrd_match_disprs1(m13), .oitfrd_match_disprs2(m23), .oitfrd_match_disprs3(m33),
      .oitfrd_match_disprd(md3), .oitf_empty(empty3), .oitf_full(full3), .oitf_cnt(cnt3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just past the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic alloc4(input logic [4:0] rd, input logic [31:0] p);
      dis_ena = 1'b1; rdwen = 1'b1; rdfpu = 1'b0; rdidx = rd; pc = p;
      step();
      dis_ena = 1'b0;
   endtask

   task automatic alloc3(input logic [4:0] rd, input logic [31:0] p);
      dis_ena3 = 1'b1; rdwen = 1'b1; rdfpu = 1'b0; rdidx = rd; pc = p;
      step();
      dis_ena3 = 1'b0;
   endtask

   task automatic cmt4(input logic [1:0] t);
      cmt_ena = 1'b1; cmt_itag = t;
      step();
      cmt_ena = 1'b0;
   endtask

   task automatic cmt3(input logic [1:0] t);
      cmt_ena3 = 1'b1; cmt_itag3 = t;
      step();
      cmt_ena3 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      dis_ena = 0; cmt_ena = 0; cmt_itag = 0; ret_ready = 0;
      dis_ena3 = 0; cmt_ena3 = 0; cmt_itag3 = 0; ret_ready3 = 0;
      rs1en = 0; rs2en = 0; rs3en = 0; rdwen = 0;
      rs1fpu = 0; rs2fpu = 0; rs3fpu = 0; rdfpu = 0;
      rs1idx = 0; rs2idx = 0; rs3idx = 0; rdidx = 0; pc = 0;
`ifdef E203_OITF_FLUSH_EN
      flush_req = 0; flush3 = 0;
`endif
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      step();

      // Reset state
      check("rst_empty", empty, 1);
      check("rst_ready", dis_ready, 1);
      check("rst_dis_ptr", dis_ptr, 0);
      check("rst_ret_valid", ret_valid, 0);
      check("rst_cnt", cnt, 0);
      check("rst_full", full, 0);
      check("rst_ret_ptr", ret_ptr, 0);
      check("rst_match_rd", md, 0);

      // Fill DEPTH=4 with x1..x4
      for (int k = 0; k < 4; k++) alloc4(5'(k + 1), 32'h100 + 32'(4 * k));
      check("fill_full", full, 1);
      check("fill_ready", dis_ready, 0);
      check("fill_cnt", cnt, 4);
      check("fill_dis_ptr", dis_ptr, 0);
      dis_ena = 1'b1;
      step();
      dis_ena = 1'b0;
      check("ovf_dis_ptr", dis_ptr, 0);
      check("ovf_cnt", cnt, 4);
      check("ovf_ret_valid", ret_valid, 0);

      // Hazard matching against x1..x4
      rs1en = 1; rs1idx = 3; rs1fpu = 0; #1;
      check("haz_rs1_hit", m1, 1);
      rs1fpu = 1; #1;
      check("haz_rs1_fpu", m1, 0);
      rs1fpu = 0; rs1idx = 9; #1;
      check("haz_rs1_miss", m1, 0);
      rdwen = 1; rdidx = 4; rdfpu = 0; #1;
      check("haz_rd_hit", md, 1);
      rs2en = 1; rs2idx = 2; rs3en = 1; rs3idx = 2; rs3fpu = 1; #1;
      check("haz_rs2_hit", m2, 1);
      check("haz_rs3_fpu", m3, 0);
      rs1en = 0; rs2en = 0; rs3en = 0; rs3fpu = 0;

      // Out-of-order completion; head only after tag 0 completes
      cmt4(3);
      cmt4(1);
      check("ooo_not_head", ret_valid, 0);
      cmt4(0);
      check("head_valid", ret_valid, 1);
      check("head_ptr", ret_ptr, 0);
      check("head_pc", ret_pc, 32'h100);
      check("head_rdidx", ret_rdidx, 1);
      check("head_rdwen", ret_rdwen, 1);

      // Backpressure hold
      for (int k = 0; k < 3; k++) begin
         step();
         check("hold_valid", ret_valid, 1);
         check("hold_ptr", ret_ptr, 0);
         check("hold_pc", ret_pc, 32'h100);
      end

      // Retire 0 then 1; head 2 is not done yet
      ret_ready = 1;
      step();
      check("ret0_ptr", ret_ptr, 1);
      check("ret0_valid", ret_valid, 1);
      check("ret0_pc", ret_pc, 32'h104);
      check("ret0_cnt", cnt, 3);
      step();
      ret_ready = 0;
      check("ret1_ptr", ret_ptr, 2);
      check("ret1_valid", ret_valid, 0);
      check("ret1_cnt", cnt, 2);
      cmt4(2);
      check("c2_valid", ret_valid, 1);
      check("c2_pc", ret_pc, 32'h108);

      // Allocate x5 + retire tag 2 + completion aimed at the new entry
      dis_ena = 1; ret_ready = 1; rdidx = 5; pc = 32'h110; cmt_ena = 1; cmt_itag = 0;
      step();
      dis_ena = 0; ret_ready = 0; cmt_ena = 0;
      check("sim_cnt", cnt, 2);
      check("sim_dis_ptr", dis_ptr, 1);
      check("sim_ret_ptr", ret_ptr, 3);
      check("sim_valid", ret_valid, 1);
      check("sim_pc", ret_pc, 32'h10C);

      rs1en = 1; rs1idx = 5; rs1fpu = 0; #1;
      check("x5_rs1_hit", m1, 1);
      rs1fpu = 1; #1;
      check("x5_rs1_fpu", m1, 0);
      rs1fpu = 0;

      ret_ready = 1;
      step();
      ret_ready = 0;
      check("ret3_ptr", ret_ptr, 0);
      check("ret3_valid", ret_valid, 0);
      check("ret3_cnt", cnt, 1);
      cmt4(2);
      check("inv_valid", ret_valid, 0);
      check("inv_cnt", cnt, 1);
      check("inv_ptr", ret_ptr, 0);
      cmt4(0);
      check("x5_valid", ret_valid, 1);
      check("x5_rdidx", ret_rdidx, 5);
      check("x5_pc", ret_pc, 32'h110);
      ret_ready = 1;
      step();
      ret_ready = 0;
      check("drain_empty", empty, 1);
      check("drain_cnt", cnt, 0);
      check("drain_ret_ptr", ret_ptr, 1);
      check("drain_dis_ptr", dis_ptr, 1);
      #1;
      check("x5_rs1_gone", m1, 0);
      rs1en = 0;

`ifdef E203_OITF_FLUSH_EN
      alloc4(6, 32'h200);
      alloc4(7, 32'h204);
      check("fl_pre_cnt", cnt, 2);
      flush_req = 1;
      step();
      flush_req = 0;
      check("fl_empty", empty, 1);
      check("fl_dis_ptr", dis_ptr, 0);
      check("fl_ret_ptr", ret_ptr, 0);
      check("fl_cnt", cnt, 0);
`endif

      // DEPTH=3: fill, then full + alloc + retire in one cycle
      for (int k = 0; k < 3; k++) alloc3(5'(k + 10), 32'h300 + 32'(4 * k));
      check("d3_full", full3, 1);
      check("d3_cnt", cnt3, 3);
      check("d3_dis_ptr", dis_ptr3, 0);
      cmt3(0);
      check("d3_valid", ret_valid3, 1);
      check("d3_pc", ret_pc3, 32'h300);
      dis_ena3 = 1; ret_ready3 = 1;
      step();
      dis_ena3 = 0; ret_ready3 = 0;
      check("d3_rej_cnt", cnt3, 2);
      check("d3_rej_dis_ptr", dis_ptr3, 0);
      check("d3_rej_ret_ptr", ret_ptr3, 1);
      check("d3_rej_full", full3, 0);

      // Interleaved allocate+retire, wrapping both pointers twice
      ea = 0; er = 1;
      for (int k = 0; k < 6; k++) begin
         cmt3(2'(er));
         dis_ena3 = 1; ret_ready3 = 1;
         step();
         dis_ena3 = 0; ret_ready3 = 0;
         ea = (ea + 1) % 3;
         er = (er + 1) % 3;
         check("wrap_cnt", cnt3, 2);
         check("wrap_dis_ptr", dis_ptr3, ea);
         check("wrap_ret_ptr", ret_ptr3, er);
         check("wrap_empty", empty3, 0);
      end
      for (int k = 0; k < 2; k++) begin
         cmt3(2'(er));
         ret_ready3 = 1;
         step();
         ret_ready3 = 0;
         er = (er + 1) % 3;
      end
      check("d3_end_empty", empty3, 1);
      check("d3_end_full", full3, 0);
      check("d3_end_cnt", cnt3, 0);
      check("d3_end_ret_ptr", ret_ptr3, er);
      for (int k = 0; k < 3; k++) alloc3(5'(k + 20), 32'h400 + 32'(4 * k));
      check("d3_refill_full", full3, 1);
      check("d3_refill_dis_ptr", dis_ptr3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
